dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache serving the memory (M) stage of the pipelined core. It is the producer of the `cache_stall` signal consumed by the hazard unit. A hit completes combinationally in the same cycle with no stall. A miss holds `cache_stall` high while the FSM writes back a dirty victim and refills the line, in word-by-word handshakes with the backing memory.

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_line_store.sv | 65 ++++++
 rtl/dcache_controller.sv | 163 ++++++++++++++++
 tb/tb_dcache_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field widths for the data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } cache_state_t;

  localparam int unsigned DEF_SETS       = 256;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned BYTE_OFF_W     = 2;

  localparam int unsigned DEF_WORD_OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int unsigned DEF_INDEX_W    = $clog2(DEF_SETS);
  localparam int unsigned DEF_TAG_W      = DEF_ADDR_W - DEF_INDEX_W - DEF_WORD_OFF_W - BYTE_OFF_W;

  // Tag width left over once byte, word and index fields are carved out of the address.
  function automatic int unsigned tagWidth(int unsigned addrW, int unsigned sets,
                                           int unsigned lineWords);
    return addrW - $clog2(sets) - $clog2(lineWords) - BYTE_OFF_W;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data storage for a direct-mapped cache; one line addressed at a time.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned TAG_W      = DEF_TAG_W
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [$clog2(SETS)-1:0]         index_i,
  output logic [TAG_W-1:0]                tag_o,
  output logic                            valid_o,
  output logic                            dirty_o,
  output logic [LINE_WORDS-1:0][31:0]     words_o,
  input  logic                            dataWe_i,
  input  logic [$clog2(LINE_WORDS)-1:0]   dataWord_i,
  input  logic [3:0]                      dataBe_i,
  input  logic [31:0]                     dataWdata_i,
  input  logic                            metaWe_i,
  input  logic [TAG_W-1:0]                metaTag_i,
  input  logic                            metaValid_i,
  input  logic                            metaDirty_i
);

  logic [TAG_W-1:0]            tagMem_q  [SETS];
  logic [LINE_WORDS-1:0][31:0] dataMem_q [SETS];
  logic [SETS-1:0]             validMem_q;
  logic [SETS-1:0]             dirtyMem_q;

  assign tag_o   = tagMem_q[index_i];
  assign valid_o = validMem_q[index_i];
  assign dirty_o = dirtyMem_q[index_i];
  assign words_o = dataMem_q[index_i];

  // Valid and dirty bits are the only state cleared by reset, which invalidates every line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      validMem_q <= '0;
      dirtyMem_q <= '0;
    end else if (metaWe_i) begin
      validMem_q[index_i] <= metaValid_i;
      dirtyMem_q[index_i] <= metaDirty_i;
    end
  end

  // Tag array has no reset; a tag is meaningless until its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (metaWe_i) begin
      tagMem_q[index_i] <= metaTag_i;
    end
  end

  // Byte-masked word write shared by store hits and refill beats.
  always_ff @(posedge clk_i) begin
    if (dataWe_i) begin
      for (int b = 0; b < 4; b++) begin
        if (dataBe_i[b]) begin
          dataMem_q[index_i][dataWord_i][8*b +: 8] <= dataWdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache with a word-serial memory port.
module dcache_controller
  import cache_pkg::*;
#(
  parameter int unsigned SETS       = DEF_SETS,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic [3:0]        cpu_be_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cache_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam int unsigned WORD_OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned INDEX_W    = $clog2(SETS);
  localparam int unsigned TAG_W      = tagWidth(ADDR_W, SETS, LINE_WORDS);
  localparam logic [WORD_OFF_W-1:0] LAST_WORD = WORD_OFF_W'(LINE_WORDS - 1);

  cache_state_t state_q, state_d;
  logic [WORD_OFF_W-1:0] counter_q, counter_d;

  logic [TAG_W-1:0]      reqTag;
  logic [INDEX_W-1:0]    reqIndex;
  logic [WORD_OFF_W-1:0] reqWord;
  logic [1:0]            unusedAddrBits;

  logic [TAG_W-1:0]            lineTag;
  logic                        lineValid;
  logic                        lineDirty;
  logic [LINE_WORDS-1:0][31:0] lineWords;

  logic                  reqActive;
  logic                  hit;
  logic                  dataWe;
  logic [WORD_OFF_W-1:0] dataWord;
  logic [3:0]            dataBe;
  logic [31:0]           dataWdata;
  logic                  metaWe;
  logic                  metaDirty;

  assign reqTag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign reqIndex       = cpu_addr_i[BYTE_OFF_W+WORD_OFF_W +: INDEX_W];
  assign reqWord        = cpu_addr_i[BYTE_OFF_W +: WORD_OFF_W];
  assign unusedAddrBits = cpu_addr_i[1:0];

  assign reqActive = cpu_rd_i | cpu_wr_i;
  assign hit       = lineValid && (lineTag == reqTag);

  cache_line_store #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .index_i     (reqIndex),
    .tag_o       (lineTag),
    .valid_o     (lineValid),
    .dirty_o     (lineDirty),
    .words_o     (lineWords),
    .dataWe_i    (dataWe),
    .dataWord_i  (dataWord),
    .dataBe_i    (dataBe),
    .dataWdata_i (dataWdata),
    .metaWe_i    (metaWe),
    .metaTag_i   (reqTag),
    .metaValid_i (1'b1),
    .metaDirty_i (metaDirty)
  );

  // State and beat counter registers; reset abandons any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Hit service, miss detection and the write-back/refill beat sequencing.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    cpu_rdata_o   = '0;
    cache_stall_o = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    dataWe        = 1'b0;
    dataWord      = reqWord;
    dataBe        = cpu_be_i;
    dataWdata     = cpu_wdata_i;
    metaWe        = 1'b0;
    metaDirty     = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqActive) begin
          if (hit) begin
            if (cpu_wr_i) begin
              dataWe    = 1'b1;
              metaWe    = 1'b1;
              metaDirty = 1'b1;
            end else begin
              cpu_rdata_o = lineWords[reqWord];
            end
          end else begin
            cache_stall_o = 1'b1;
            counter_d     = '0;
            state_d       = (lineValid && lineDirty) ? WRITEBACK : REFILL;
          end
        end
      end
      WRITEBACK: begin
        cache_stall_o = 1'b1;
        mem_req_o     = 1'b1;
        mem_we_o      = 1'b1;
        mem_addr_o    = {lineTag, reqIndex, counter_q, 2'b00};
        mem_wdata_o   = lineWords[counter_q];
        if (mem_ready_i) begin
          counter_d = counter_q + 1'b1;
          if (counter_q == LAST_WORD) begin
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        cache_stall_o = 1'b1;
        mem_req_o     = 1'b1;
        mem_addr_o    = {reqTag, reqIndex, counter_q, 2'b00};
        if (mem_ready_i) begin
          dataWe    = 1'b1;
          dataWord  = counter_q;
          dataBe    = 4'hF;
          dataWdata = mem_rdata_i;
          counter_d = counter_q + 1'b1;
          if (counter_q == LAST_WORD) begin
            metaWe  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a line-level cache model and a memory responder.
module tb_dcache_controller;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cache_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Model of cache contents, backing memory and the transfers expected for the current request.
  logic [19:0] mTag  [256];
  bit          mValid[256];
  bit          mDirty[256];
  logic [31:0] mData [256][4];
  logic [31:0] benchMem [logic [31:0]];
  txn_t        expTxn[$];

  bit          checkEn = 0;
  bit          reqActive = 0;
  bit          missPending = 0;
  bit          firstCycle = 0;
  bit          expLoad = 0;
  bit          reqDone = 0;
  logic [31:0] expRdata = '0;
  logic [31:0] lastRdata = '0;
  int          stallCount = 0;
  int          respGap = 1;
  int          waitCnt = 0;
  int          beatCount = 0;

  dcache_controller dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_rd_i      (cpu_rd),
    .cpu_wr_i      (cpu_wr),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_be_i      (cpu_be),
    .cpu_rdata_o   (cpu_rdata),
    .cache_stall_o (cache_stall),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_ready_i   (mem_ready),
    .mem_rdata_i   (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (benchMem.exists(a)) return benchMem[a];
    return 32'hA000_0000 + a;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: a beat is accepted when mem_ready is high in a cycle with mem_req.
  always @(negedge clk) begin
    if (mem_req && mem_ready) begin
      beatCount++;
      if (mem_we) benchMem[mem_addr] = mem_wdata;
    end
  end

  // Ready is raised once every respGap cycles of an outstanding request.
  always @(posedge clk) begin
    #2;
    if (mem_req) begin
      waitCnt++;
      if (waitCnt >= respGap) begin
        mem_ready = 1'b1;
        waitCnt   = 0;
      end else begin
        mem_ready = 1'b0;
      end
      mem_rdata = memRead(mem_addr);
    end else begin
      mem_ready = 1'b0;
      waitCnt   = 0;
      mem_rdata = '0;
    end
  end

  // Per-cycle comparison of DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (checkEn) begin
      if (!reqActive) begin
        checkOutput("idle_stall", 32'(cache_stall), 32'd0);
        checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
        checkOutput("idle_rdata", cpu_rdata, 32'd0);
      end else begin
        checkOutput("stall", 32'(cache_stall), 32'(missPending));
        if (firstCycle) begin
          checkOutput("detect_mem_req", 32'(mem_req), 32'd0);
          firstCycle = 0;
        end else if (missPending) begin
          checkOutput("xfer_mem_req", 32'(mem_req), 32'd1);
          if (expTxn.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL xfer_queue: transfer seen with none expected at %0t", $time);
          end else if (mem_req) begin
            checkOutput("xfer_we", 32'(mem_we), 32'(expTxn[0].we));
            checkOutput("xfer_addr", mem_addr, expTxn[0].addr);
            if (expTxn[0].we) checkOutput("xfer_wdata", mem_wdata, expTxn[0].data);
            if (mem_ready) begin
              void'(expTxn.pop_front());
              if (expTxn.size() == 0) missPending = 0;
            end
          end
        end else begin
          checkOutput("hit_mem_req", 32'(mem_req), 32'd0);
        end
        if (cache_stall) begin
          stallCount++;
          checkOutput("stall_rdata", cpu_rdata, 32'd0);
        end else begin
          if (expLoad) checkOutput("load_rdata", cpu_rdata, expRdata);
          lastRdata = cpu_rdata;
          reqDone   = 1;
        end
      end
    end
  end

  // Plan one request in the model, present it, and hold it until the cache stops stalling.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input int gap,
                               output int stalls, output logic [31:0] rdata);
    int          s, w, beats, n;
    logic [19:0] t;
    logic [31:0] base, vbase;
    bit          hitNow;
    s     = int'((addr >> 4) & 32'hFF);
    w     = int'((addr >> 2) & 32'h3);
    t     = addr[31:12];
    base  = {addr[31:4], 4'h0};
    beats = 0;
    expTxn.delete();
    hitNow = mValid[s] && (mTag[s] == t);
    if (!hitNow) begin
      if (mValid[s] && mDirty[s]) begin
        vbase = {mTag[s], 8'(s), 4'h0};
        for (int k = 0; k < 4; k++) expTxn.push_back('{1'b1, vbase + 32'(4*k), mData[s][k]});
        beats += 4;
      end
      for (int k = 0; k < 4; k++) begin
        expTxn.push_back('{1'b0, base + 32'(4*k), 32'd0});
        mData[s][k] = memRead(base + 32'(4*k));
      end
      beats += 4;
      mTag[s]   = t;
      mValid[s] = 1;
      mDirty[s] = 0;
    end
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) mData[s][w][8*b +: 8] = wdata[8*b +: 8];
      mDirty[s] = 1;
    end
    expLoad     = rd && !wr;
    expRdata    = mData[s][w];
    missPending = !hitNow;
    firstCycle  = !hitNow;
    stallCount  = 0;
    reqDone     = 0;
    respGap     = gap;
    @(posedge clk);
    #1;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_be    = be;
    reqActive = 1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!reqDone && n < 300);
    if (!reqDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL request_timeout: addr 0x%08h still stalled after %0d cycles", addr, n);
    end
    checkOutput("stall_cycles", 32'(stallCount), hitNow ? 32'd0 : 32'(1 + beats*gap));
    stalls    = stallCount;
    rdata     = lastRdata;
    cpu_rd    = 0;
    cpu_wr    = 0;
    reqActive = 0;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 256; i++) begin
      mValid[i] = 0;
      mDirty[i] = 0;
    end
    expTxn.delete();
    missPending = 0;
    firstCycle  = 0;
  endtask

  initial begin
    int          st, n, startBeats;
    logic [31:0] rd;
    rst       = 1;
    cpu_rd    = 0;
    cpu_wr    = 0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_be    = '0;
    mem_ready = 0;
    mem_rdata = '0;
    benchMem[32'h2000] = 32'h1122_3344;
    resetModel();

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", 32'(cache_stall), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_rdata", cpu_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst     = 0;
    checkEn = 1;

    $display("[TB] cold read miss and read hit");
    applyStimulus(1, 0, 32'h1000, 0, 4'h0, 1, st, rd);
    checkOutput("cold_miss_stall", 32'(st), 32'd5);
    checkOutput("cold_miss_rdata", rd, 32'hA000_1000);
    applyStimulus(1, 0, 32'h1008, 0, 4'h0, 1, st, rd);
    checkOutput("hit_stall", 32'(st), 32'd0);
    checkOutput("hit_rdata", rd, 32'hA000_1008);

    $display("[TB] write hit then conflicting dirty miss");
    applyStimulus(0, 1, 32'h1004, 32'hDEAD_BEEF, 4'hF, 1, st, rd);
    checkOutput("write_hit_stall", 32'(st), 32'd0);
    applyStimulus(1, 0, 32'h2000, 0, 4'h0, 1, st, rd);
    checkOutput("dirty_miss_stall", 32'(st), 32'd9);
    checkOutput("dirty_miss_rdata", rd, 32'h1122_3344);
    checkOutput("wb_word1", memRead(32'h1004), 32'hDEAD_BEEF);
    checkOutput("wb_word3", memRead(32'h100C), 32'hA000_100C);

    $display("[TB] byte enables");
    applyStimulus(0, 1, 32'h2000, 32'h0000_00AA, 4'b0001, 1, st, rd);
    applyStimulus(1, 0, 32'h2000, 0, 4'hF, 1, st, rd);
    checkOutput("byte_merge_rdata", rd, 32'h1122_33AA);

    $display("[TB] memory wait states");
    applyStimulus(1, 0, 32'h3010, 0, 4'h0, 3, st, rd);
    checkOutput("wait_miss_stall", 32'(st), 32'd13);
    checkOutput("wait_miss_rdata", rd, 32'hA000_3010);

    $display("[TB] store miss, dual request, dirty eviction with waits");
    applyStimulus(0, 1, 32'h6040, 32'h1234_5678, 4'b1100, 1, st, rd);
    checkOutput("store_miss_stall", 32'(st), 32'd5);
    applyStimulus(1, 0, 32'h6040, 0, 4'h0, 1, st, rd);
    checkOutput("store_miss_rdata", rd, 32'h1234_6040);
    applyStimulus(1, 1, 32'h6044, 32'hCAFE_F00D, 4'hF, 1, st, rd);
    checkOutput("dual_req_stall", 32'(st), 32'd0);
    applyStimulus(1, 0, 32'h6044, 0, 4'h0, 1, st, rd);
    checkOutput("dual_req_rdata", rd, 32'hCAFE_F00D);
    applyStimulus(1, 0, 32'h7040, 0, 4'h0, 2, st, rd);
    checkOutput("evict_wait_stall", 32'(st), 32'd17);
    checkOutput("evict_wb_word0", memRead(32'h6040), 32'h1234_6040);
    checkOutput("evict_wb_word1", memRead(32'h6044), 32'hCAFE_F00D);

    $display("[TB] reset during refill");
    checkEn    = 0;
    respGap    = 1;
    startBeats = beatCount;
    @(posedge clk);
    #1;
    cpu_rd   = 1;
    cpu_addr = 32'h4020;
    n = 0;
    while (beatCount < startBeats + 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("refill_beats_before_rst", 32'(beatCount - startBeats), 32'd2);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_rehit_stall", 32'(cache_stall), 32'd1);
    @(posedge clk);
    #1;
    rst    = 0;
    cpu_rd = 0;
    resetModel();
    @(posedge clk);
    #1;
    checkEn = 1;
    applyStimulus(1, 0, 32'h4020, 0, 4'h0, 1, st, rd);
    checkOutput("post_rst_miss_stall", 32'(st), 32'd5);
    checkOutput("post_rst_rdata", rd, 32'hA000_4020);
    applyStimulus(1, 0, 32'h1008, 0, 4'h0, 1, st, rd);
    checkOutput("post_rst_old_line_stall", 32'(st), 32'd5);
    checkOutput("post_rst_old_line_rdata", rd, 32'hA000_1008);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
